// File: rtl/tinyrv1_pkg.sv
// TinyRV1 shared encoding constants, op enum and immediate-type codes.
// Imported by the encoder and its immediate packer.
package tinyrv1_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_ADDI = 3'd1,
        OP_MUL  = 3'd2,
        OP_LW   = 3'd3,
        OP_SW   = 3'd4,
        OP_JAL  = 3'd5,
        OP_JR   = 3'd6,
        OP_BNE  = 3'd7
    } op_e;

    // Same code points the decoder uses for its immediate generator.
    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_J    = 3'd3,
        IMM_NONE = 3'd7
    } imm_type_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_MUL = 7'b0000001;

    localparam int I_MIN = -2048;
    localparam int I_MAX = 2047;
    localparam int B_MIN = -4096;
    localparam int B_MAX = 4094;
    localparam int J_MIN = -1048576;
    localparam int J_MAX = 1048574;

    typedef struct packed {
        op_e         op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm_field;
        logic        err;
    } s1_t;

    function automatic imm_type_e imm_type_of(op_e op);
        imm_type_e t;
        t = IMM_NONE;
        unique case (op)
            OP_ADDI, OP_LW: t = IMM_I;
            OP_SW:          t = IMM_S;
            OP_BNE:         t = IMM_B;
            OP_JAL:         t = IMM_J;
            default:        t = IMM_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/inst_encoder_imm_pack.sv
// Scatters a signed immediate into its I/S/B/J bit positions and
// flags out-of-range or misaligned values (field is zero on error).
module imm_pack
    import tinyrv1_pkg::*;
(
    input  logic [31:0] imm,
    input  imm_type_e   imm_type,
    output logic [31:0] field,
    output logic        err
);

    logic signed [31:0] s;
    logic [31:0] raw;

    assign s = imm;

    always_comb begin
        err = 1'b0;
        raw = '0;
        unique case (imm_type)
            IMM_I: begin
                err = (s < I_MIN) || (s > I_MAX);
                raw = {imm[11:0], 20'b0};
            end
            IMM_S: begin
                err = (s < I_MIN) || (s > I_MAX);
                raw = {imm[11:5], 13'b0, imm[4:0], 7'b0};
            end
            IMM_B: begin
                err = (s < B_MIN) || (s > B_MAX) || imm[0];
                raw = {imm[12], imm[10:5], 13'b0,
                       imm[4:1], imm[11], 7'b0};
            end
            IMM_J: begin
                err = (s < J_MIN) || (s > J_MAX) || imm[0];
                raw = {imm[20], imm[10:1], imm[11],
                       imm[19:12], 12'b0};
            end
            default: begin
                err = 1'b0;
                raw = '0;
            end
        endcase
        field = err ? '0 : raw;
    end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage TinyRV1 instruction encoder: S1 range-checks and scatters
// the immediate, S2 assembles the 32-bit word behind a val/rdy output.
module inst_encoder
    import tinyrv1_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_val,
    output logic                 in_rdy,
    input  logic [2:0]           in_op,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [31:0]          in_imm,
    output logic                 out_val,
    input  logic                 out_rdy,
    output logic [31:0]          out_inst,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    op_e   in_op_e;
    s1_t   s1;
    s1_t   s1_nxt;
    logic  s1_val;
    logic  s2_val;
    logic  s2_adv;
    logic  [31:0] imm_field;
    logic  imm_err;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd_m;
    logic [4:0]  rs1_m;
    logic [4:0]  rs2_m;
    logic [31:0] word;

    assign in_op_e = op_e'(in_op);

    imm_pack u_imm_pack (
        .imm      (in_imm),
        .imm_type (imm_type_of(in_op_e)),
        .field    (imm_field),
        .err      (imm_err)
    );

    assign s1_nxt = '{op: in_op_e, rd: in_rd, rs1: in_rs1,
                      rs2: in_rs2, imm_field: imm_field,
                      err: imm_err};

    assign s2_adv  = !s2_val || out_rdy;
    assign in_rdy  = !s1_val || s2_adv;
    assign out_val = s2_val;

    // Unused register fields are forced to zero per op.
    always_comb begin
        opc   = '0;
        f3    = '0;
        f7    = '0;
        rd_m  = '0;
        rs1_m = '0;
        rs2_m = '0;
        unique case (s1.op)
            OP_ADD, OP_MUL: begin
                opc   = OPC_OP;
                f3    = F3_ADD;
                f7    = (s1.op == OP_MUL) ? F7_MUL : F7_ADD;
                rd_m  = s1.rd;
                rs1_m = s1.rs1;
                rs2_m = s1.rs2;
            end
            OP_ADDI: begin
                opc   = OPC_OPIMM;
                f3    = F3_ADDI;
                rd_m  = s1.rd;
                rs1_m = s1.rs1;
            end
            OP_LW: begin
                opc   = OPC_LOAD;
                f3    = F3_LW;
                rd_m  = s1.rd;
                rs1_m = s1.rs1;
            end
            OP_SW: begin
                opc   = OPC_STORE;
                f3    = F3_SW;
                rs1_m = s1.rs1;
                rs2_m = s1.rs2;
            end
            OP_BNE: begin
                opc   = OPC_BRANCH;
                f3    = F3_BNE;
                rs1_m = s1.rs1;
                rs2_m = s1.rs2;
            end
            OP_JAL: begin
                opc  = OPC_JAL;
                rd_m = s1.rd;
            end
            OP_JR: begin
                opc   = OPC_JALR;
                f3    = F3_JALR;
                rs1_m = s1.rs1;
            end
            default: begin
                opc = '0;
            end
        endcase
    end

    assign word = {f7, rs2_m, rs1_m, f3, rd_m, opc} | s1.imm_field;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_val    <= 1'b0;
            s2_val    <= 1'b0;
            s1        <= '0;
            out_inst  <= '0;
            out_err   <= 1'b0;
            err_count <= '0;
        end else begin
            if (in_rdy) begin
                s1_val <= in_val;
                if (in_val) s1 <= s1_nxt;
            end
            if (s2_adv) begin
                s2_val <= s1_val;
                if (s1_val) begin
                    out_inst <= word;
                    out_err  <= s1.err;
                end
            end
            if (out_val && out_rdy && out_err && (err_count != '1))
                err_count <= err_count + ERR_CNT_W'(1);
        end
    end

endmodule
